// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: instruction-fetch front end.
// Keeps its own fetch PC and issues one outstanding imem request at a time
// over a req/ack handshake. Returned words are queued with their PC in a
// DEPTH-entry circular buffer and handed to decode over valid/ready.
// A redirect flushes the queue and restarts fetch at the new target. If a
// request is still in flight at that moment, its late response is dropped.
//
// Optional build macro: FETCH_STAT_EN adds the stall_cycles and
// flush_count statistics outputs.
//
// state  | meaning
// S_IDLE | first cycle out of reset, no request yet
// S_REQ  | request presented whenever the queue has room
// S_WAIT | request outstanding, response will be queued
// S_DROP | request outstanding but flushed, response will be discarded
module fetch_queue_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     imem_req,
  output logic [ADDR_W-1:0]        imem_addr,
  input  logic                     imem_ack,
  input  logic [DATA_W-1:0]        imem_rdata,
  input  logic                     redirect,
  input  logic [ADDR_W-1:0]        redirect_pc,
  output logic                     inst_valid,
  input  logic                     inst_ready,
  output logic [DATA_W-1:0]        inst_data,
  output logic [ADDR_W-1:0]        inst_pc,
  output logic [ADDR_W-1:0]        inst_pc4,
  output logic [$clog2(DEPTH):0]   count
`ifdef FETCH_STAT_EN
  ,
  output logic [31:0]              stall_cycles,
  output logic [31:0]              flush_count
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DROP = 2'd3
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [ADDR_W-1:0] fetch_pc;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem   [DEPTH];

  logic full;
  logic push;
  logic pop;

  assign full       = (count == FULL_CNT);
  assign inst_valid = (count != '0);
  assign pop        = inst_valid && inst_ready && !redirect;
  assign imem_addr  = fetch_pc;

  // Queue head; all zero while empty so decode never sees stale words.
  always_comb begin
    inst_data = '0;
    inst_pc   = '0;
    inst_pc4  = '0;
    if (inst_valid) begin
      inst_data = data_mem[rd_ptr];
      inst_pc   = pc_mem[rd_ptr];
      inst_pc4  = pc_mem[rd_ptr] + PC_STEP;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, request strobe and push decision.
  always_comb begin
    state_d  = state_q;
    imem_req = 1'b0;
    push     = 1'b0;
    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
      end
      S_REQ: begin
        // Uses the registered count, so a pop cannot release a full queue
        // in the same cycle.
        imem_req = !full && !redirect;
        if (imem_req) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_ack) begin
          push    = !redirect;
          state_d = S_REQ;
        end else if (redirect) begin
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        // An ack here always retires the stale request; a redirect in the
        // same cycle has already updated the PC, so fetch can resume.
        if (imem_ack) begin
          state_d = S_REQ;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Fetch PC, queue pointers and occupancy; redirect overrides push/pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc & ALIGN_MASK;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        fetch_pc <= fetch_pc + PC_STEP;
        wr_ptr   <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Queue storage; contents are qualified by count, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= imem_rdata;
      pc_mem[wr_ptr]   <= fetch_pc;
    end
  end

`ifdef FETCH_STAT_EN
  // Saturating stall and flush statistics.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if ((state_q == S_REQ) && full && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if (redirect && (flush_count != '1)) begin
        flush_count <= flush_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: a latency-configurable memory responder,
// a scoreboard of expected delivered PCs, a redirect vector table and
// hand-written reset / narrow-address sequences.
module tb_fetch_queue_unit;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [DW-1:0] imem_rdata;
  logic          redirect;
  logic [AW-1:0] redirect_pc;
  logic          inst_valid;
  logic          inst_ready;
  logic [DW-1:0] inst_data;
  logic [AW-1:0] inst_pc;
  logic [AW-1:0] inst_pc4;
  logic [2:0]    count;

  logic          b_imem_req;
  logic [7:0]    b_imem_addr;
  logic          b_imem_ack;
  logic [DW-1:0] b_imem_rdata;
  logic          b_redirect;
  logic [7:0]    b_redirect_pc;
  logic          b_inst_valid;
  logic          b_inst_ready;
  logic [DW-1:0] b_inst_data;
  logic [7:0]    b_inst_pc;
  logic [7:0]    b_inst_pc4;
  logic [2:0]    b_count;

`ifdef FETCH_STAT_EN
  logic [31:0] stall_cycles, flush_count, b_stall_cycles, b_flush_count;
`endif

  fetch_queue_unit #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data),
    .inst_pc(inst_pc), .inst_pc4(inst_pc4), .count(count)
`ifdef FETCH_STAT_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
  );

  fetch_queue_unit #(.ADDR_W(8), .DATA_W(DW), .DEPTH(DEPTH), .RESET_PC(8'h0)) dut_b (
    .clk(clk), .reset(reset),
    .imem_req(b_imem_req), .imem_addr(b_imem_addr), .imem_ack(b_imem_ack), .imem_rdata(b_imem_rdata),
    .redirect(b_redirect), .redirect_pc(b_redirect_pc),
    .inst_valid(b_inst_valid), .inst_ready(b_inst_ready), .inst_data(b_inst_data),
    .inst_pc(b_inst_pc), .inst_pc4(b_inst_pc4), .count(b_count)
`ifdef FETCH_STAT_EN
    , .stall_cycles(b_stall_cycles), .flush_count(b_flush_count)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [AW-1:0] exp_q   [$];
  logic [AW-1:0] req_log [$];

  bit            mem_busy;
  logic [AW-1:0] mem_addr;
  int            mem_cnt;
  int            mem_lat;
  bit            hold_ready;

  logic          smp_req;
  logic [AW-1:0] smp_addr;
  logic [2:0]    smp_count;
  logic          smp_valid;
  logic [DW-1:0] smp_data;
  logic [AW-1:0] smp_pc;
  logic [AW-1:0] smp_pc4;

  typedef struct {
    logic [AW-1:0] rpc;
    bit            ack_same;
    logic [AW-1:0] exp_pc;
  } redir_vec_t;

  redir_vec_t tbl [4];

  function automatic logic [DW-1:0] mk_data(input logic [AW-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // One clock: memory responds, outputs sampled after the falling edge,
  // deliveries checked against the scoreboard, new requests captured.
  task automatic cycle();
    logic [AW-1:0] e;
    logic [AW-1:0] e4;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = '0;
    if (mem_busy) begin
      if (mem_cnt > 1) begin
        mem_cnt--;
      end else begin
        imem_ack   = 1'b1;
        imem_rdata = mk_data(mem_addr);
        mem_busy   = 1'b0;
      end
    end
    inst_ready = !hold_ready && (exp_q.size() != 0);
    #1;
    smp_req   = imem_req;
    smp_addr  = imem_addr;
    smp_count = count;
    smp_valid = inst_valid;
    smp_data  = inst_data;
    smp_pc    = inst_pc;
    smp_pc4   = inst_pc4;
    if (inst_valid && inst_ready && !redirect) begin
      e  = exp_q.pop_front();
      e4 = e + 32'd4;
      chk("deliver_pc", inst_pc, e);
      chk("deliver_data", inst_data, mk_data(e));
      chk("deliver_pc4", inst_pc4, e4);
    end
    if (imem_req) begin
      mem_busy = 1'b1;
      mem_addr = imem_addr;
      mem_cnt  = mem_lat;
      req_log.push_back(imem_addr);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input string name, input int budget);
    bit got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      cycle();
      got = smp_req;
    end
    if (!got) timeout(name);
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) begin
      cycle();
    end
    if (exp_q.size() != 0) timeout(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] nxt;
    tbl[0] = '{32'h0000_0100, 1'b0, 32'h0000_0100};
    tbl[1] = '{32'h0000_0203, 1'b1, 32'h0000_0200};
    tbl[2] = '{32'hFFFF_FFFE, 1'b0, 32'hFFFF_FFFC};
    tbl[3] = '{32'h0000_0045, 1'b1, 32'h0000_0044};

    reset = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_ack = 1'b0; imem_rdata = '0; inst_ready = 1'b0;
    b_redirect = 1'b0; b_redirect_pc = '0; b_imem_ack = 1'b0;
    b_imem_rdata = '0; b_inst_ready = 1'b0;
    mem_busy = 1'b0; mem_cnt = 0; mem_lat = 1; hold_ready = 1'b0;

    // Reset values.
    cycle();
    cycle();
    chk("rst_req", smp_req, 0);
    chk("rst_addr", smp_addr, 0);
    chk("rst_valid", smp_valid, 0);
    chk("rst_count", smp_count, 0);
    chk("rst_data", smp_data, 0);
    chk("rst_pc", smp_pc, 0);
    chk("rst_pc4", smp_pc4, 0);
    chk("rst_b_req", b_imem_req, 0);

    // Streaming fetch with single-cycle-ack memory.
    req_log.delete();
    exp_q.delete();
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    reset = 1'b1;
    wait_drain("t1_drain", 40);
    cycle();
    chk("t1_nreq_ge4", req_log.size() >= 4, 1);
    for (int i = 0; i < 4; i++) begin
      if (req_log.size() > i) chk("t1_req_addr", req_log[i], 64'(i * 4));
    end

    // Backpressure: queue fills, request held off, pop frees a slot.
    reset = 1'b0;
    mem_busy = 1'b0;
    hold_ready = 1'b1;
    exp_q.delete();
    cycle();
    reset = 1'b1;
    req_log.delete();
    repeat (20) cycle();
    chk("t2_nreq", req_log.size(), 4);
    chk("t2_count_full", smp_count, 4);
    chk("t2_req_blocked", smp_req, 0);
    hold_ready = 1'b0;
    exp_q.push_back(32'h0);
    cycle();
    chk("t2_popped", exp_q.size(), 0);
    chk("t2_req_pop_cycle", smp_req, 0);
    cycle();
    chk("t2_count_after_pop", smp_count, 3);
    chk("t2_req_after_pop", smp_req, 1);
    chk("t2_addr_after_pop", smp_addr, 32'h10);

    // Redirect vectors with a 3-cycle memory, one word already queued.
    mem_lat = 3;
    for (int v = 0; v < 4; v++) begin
      redirect = 1'b1;
      redirect_pc = 32'h1000;
      cycle();
      redirect = 1'b0;
      exp_q.delete();
      wait_req("t3_first_req", 30);
      wait_req("t3_second_req", 30);
      chk("t3_count_pre", smp_count, 1);
      if (tbl[v].ack_same) begin
        cycle();
        cycle();
      end
      redirect = 1'b1;
      redirect_pc = tbl[v].rpc;
      cycle();
      redirect = 1'b0;
      chk("t3_req_in_redirect", smp_req, 0);
      cycle();
      chk("t3_count_flushed", smp_count, 0);
      nxt = tbl[v].exp_pc + 32'd4;
      exp_q.push_back(tbl[v].exp_pc);
      exp_q.push_back(nxt);
      if (!smp_req) wait_req("t3_req", 30);
      chk("t3_addr", smp_addr, tbl[v].exp_pc);
      wait_drain("t3_drain", 60);
    end

    // Reset while a request is outstanding; its ack lands after release.
    redirect = 1'b1;
    redirect_pc = 32'h2000;
    cycle();
    redirect = 1'b0;
    exp_q.delete();
    wait_req("t4_req", 30);
    reset = 1'b0;
    cycle();
    chk("t4_rst_req", smp_req, 0);
    chk("t4_rst_addr", smp_addr, 0);
    chk("t4_rst_count", smp_count, 0);
    reset = 1'b1;
    exp_q.push_back(32'h0);
    wait_req("t4_req_after_reset", 10);
    chk("t4_addr_after_reset", smp_addr, 0);
    chk("t4_count_after_reset", smp_count, 0);
    cycle();
    chk("t4_count_after_stray", smp_count, 0);
    wait_drain("t4_drain", 30);

    // 8-bit address instance: fetch wraps from 0xFC to 0x00.
    @(negedge clk);
    b_redirect = 1'b1;
    b_redirect_pc = 8'hFC;
    #1;
    chk("t5_req_in_redirect", b_imem_req, 0);
    @(posedge clk); #1;
    @(negedge clk);
    b_redirect = 1'b0;
    b_imem_ack = 1'b1;
    b_imem_rdata = 32'hDEAD_00FC;
    #1;
    chk("t5_count_flushed", b_count, 0);
    @(posedge clk); #1;
    @(negedge clk);
    b_imem_ack = 1'b0;
    #1;
    chk("t5_req", b_imem_req, 1);
    chk("t5_addr_fc", b_imem_addr, 8'hFC);
    @(posedge clk); #1;
    @(negedge clk);
    b_imem_ack = 1'b1;
    b_imem_rdata = 32'hCAFE_0001;
    @(posedge clk); #1;
    @(negedge clk);
    b_imem_ack = 1'b0;
    #1;
    chk("t5_addr_wrap", b_imem_addr, 8'h00);
    chk("t5_count", b_count, 1);
    chk("t5_inst_pc", b_inst_pc, 8'hFC);
    chk("t5_inst_pc4", b_inst_pc4, 8'h00);
    chk("t5_inst_data", b_inst_data, 32'hCAFE_0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
